// File: rtl/demux_1to2_reg.sv
// demux_1to2_reg: 1-to-2 valid/ready demultiplexer with one holding register
// per output port. The selected port accepts a new payload whenever its
// register is empty or is draining on the same edge, so each port sustains
// one transfer per cycle and a stalled port never blocks the other one.
// Each port also keeps an 8-bit wrapping count of delivered transfers.

module demux_1to2_reg #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_sel,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data0,
    output logic [WIDTH-1:0] o_data1,
    output logic             o_valid0,
    output logic             o_valid1,
    input  logic             i_ready0,
    input  logic             i_ready1,
    output logic [7:0]       o_cnt0,
    output logic [7:0]       o_cnt1
);

    // Holding registers and delivery counters
    logic [WIDTH-1:0] data0_r;
    logic [WIDTH-1:0] data1_r;
    logic             valid0_r;
    logic             valid1_r;
    logic [7:0]       cnt0_r;
    logic [7:0]       cnt1_r;

    // Handshake decode
    logic             ready_s;
    logic             load0_s;
    logic             load1_s;
    logic             drain0_s;
    logic             drain1_s;

    // Decode ready and the per-port load/drain strobes; ready never looks at
    // i_valid and is forced low while reset is held.
    always_comb begin
        ready_s  = 1'b0;
        load0_s  = 1'b0;
        load1_s  = 1'b0;
        drain0_s = valid0_r & i_ready0;
        drain1_s = valid1_r & i_ready1;
        if (i_rst_n == 1'b0) begin
            ready_s = 1'b0;
        end else if (i_sel == 1'b0) begin
            ready_s = (~valid0_r) | i_ready0;
        end else begin
            ready_s = (~valid1_r) | i_ready1;
        end
        if ((i_valid & ready_s) == 1'b1) begin
            load0_s = ~i_sel;
            load1_s = i_sel;
        end else begin
            load0_s = 1'b0;
            load1_s = 1'b0;
        end
    end

    // Port 0 holding register: load wins over drain, data held otherwise.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data0_r  <= {WIDTH{1'b0}};
            valid0_r <= 1'b0;
        end else if (load0_s) begin
            data0_r  <= i_data;
            valid0_r <= 1'b1;
        end else if (drain0_s) begin
            valid0_r <= 1'b0;
        end
    end

    // Port 1 holding register: load wins over drain, data held otherwise.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data1_r  <= {WIDTH{1'b0}};
            valid1_r <= 1'b0;
        end else if (load1_s) begin
            data1_r  <= i_data;
            valid1_r <= 1'b1;
        end else if (drain1_s) begin
            valid1_r <= 1'b0;
        end
    end

    // Delivered-transfer counters, wrapping naturally at 8 bits.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt0_r <= 8'd0;
            cnt1_r <= 8'd0;
        end else begin
            if (drain0_s) begin
                cnt0_r <= cnt0_r + 8'd1;
            end
            if (drain1_s) begin
                cnt1_r <= cnt1_r + 8'd1;
            end
        end
    end

    assign o_ready  = ready_s;
    assign o_data0  = data0_r;
    assign o_data1  = data1_r;
    assign o_valid0 = valid0_r;
    assign o_valid1 = valid1_r;
    assign o_cnt0   = cnt0_r;
    assign o_cnt1   = cnt1_r;

endmodule

// File: tb/tb_demux_1to2_reg.sv
// Self-checking bench for demux_1to2_reg: a directed vector table followed by
// hand-written multi-cycle sequences and a randomised scoreboard run.

module tb_demux_1to2_reg;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] data;
    logic         sel;
    logic         valid;
    logic         rdy0;
    logic         rdy1;
    logic         ready;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic         v0;
    logic         v1;
    logic [7:0]   c0;
    logic [7:0]   c1;

    int n_checks = 0;
    int n_errors = 0;

    demux_1to2_reg #(.WIDTH(W)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_data   (data),
        .i_sel    (sel),
        .i_valid  (valid),
        .o_ready  (ready),
        .o_data0  (d0),
        .o_data1  (d1),
        .o_valid0 (v0),
        .o_valid1 (v1),
        .i_ready0 (rdy0),
        .i_ready1 (rdy1),
        .o_cnt0   (c0),
        .o_cnt1   (c1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         v;
        logic         s;
        logic [31:0]  d;
        logic         r0;
        logic         r1;
        logic         e_rdy;
        logic         e_v0;
        logic [31:0]  e_d0;
        logic         e_v1;
        logic [31:0]  e_d1;
        logic [7:0]   e_c0;
        logic [7:0]   e_c1;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid = 1'b0;
        sel   = 1'b0;
        data  = 32'h0;
        rdy0  = 1'b0;
        rdy1  = 1'b0;
    endtask

    // Hold reset over two edges, check reset values, release after an edge.
    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid0", {31'b0, v0}, 32'h0);
        chk("rst_valid1", {31'b0, v1}, 32'h0);
        chk("rst_data0", d0, 32'h0);
        chk("rst_data1", d1, 32'h0);
        chk("rst_cnt0", {24'b0, c0}, 32'h0);
        chk("rst_cnt1", {24'b0, c1}, 32'h0);
        chk("rst_ready", {31'b0, ready}, 32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] q0[$];
        logic [31:0] q1[$];
        logic [7:0]  ec0;
        logic [7:0]  ec1;
        logic        e_rdy;
        logic        acc;

        //            v     s     d             r0    r1    rdy   v0    d0            v1    d1     c0    c1
        tbl[0] = '{1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0,  8'd0, 8'd0};
        tbl[1] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0,  8'd1, 8'd0};
        tbl[2] = '{1'b1, 1'b1, 32'h22,       1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 32'h22, 8'd1, 8'd0};
        tbl[3] = '{1'b1, 1'b1, 32'h33,       1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 32'h22, 8'd1, 8'd0};
        tbl[4] = '{1'b1, 1'b0, 32'h44,       1'b0, 1'b0, 1'b1, 1'b1, 32'h44,       1'b1, 32'h22, 8'd1, 8'd0};
        tbl[5] = '{1'b1, 1'b1, 32'h55,       1'b0, 1'b1, 1'b1, 1'b1, 32'h44,       1'b1, 32'h55, 8'd1, 8'd1};
        tbl[6] = '{1'b1, 1'b0, 32'h66,       1'b0, 1'b1, 1'b0, 1'b1, 32'h44,       1'b0, 32'h55, 8'd1, 8'd2};
        tbl[7] = '{1'b0, 1'b0, 32'h77,       1'b1, 1'b0, 1'b1, 1'b0, 32'h44,       1'b0, 32'h55, 8'd2, 8'd2};
        tbl[8] = '{1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h44,       1'b0, 32'h55, 8'd2, 8'd2};

        do_reset();

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            valid = tbl[i].v;
            sel   = tbl[i].s;
            data  = tbl[i].d;
            rdy0  = tbl[i].r0;
            rdy1  = tbl[i].r1;
            #1;
            chk($sformatf("vec%0d_ready", i), {31'b0, ready}, {31'b0, tbl[i].e_rdy});
            step();
            chk($sformatf("vec%0d_valid0", i), {31'b0, v0}, {31'b0, tbl[i].e_v0});
            chk($sformatf("vec%0d_data0", i), d0, tbl[i].e_d0);
            chk($sformatf("vec%0d_valid1", i), {31'b0, v1}, {31'b0, tbl[i].e_v1});
            chk($sformatf("vec%0d_data1", i), d1, tbl[i].e_d1);
            chk($sformatf("vec%0d_cnt0", i), {24'b0, c0}, {24'b0, tbl[i].e_c0});
            chk($sformatf("vec%0d_cnt1", i), {24'b0, c1}, {24'b0, tbl[i].e_c1});
        end

        // Port 0 stalled full with 0x11; port 1 traffic still flows.
        idle_inputs();
        valid = 1'b1; sel = 1'b0; data = 32'h11;
        step();
        data = 32'h99;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("stall_ready", {31'b0, ready}, 32'h0);
            step();
            chk("stall_data0", d0, 32'h11);
            chk("stall_valid0", {31'b0, v0}, 32'h1);
        end
        sel = 1'b1; data = 32'h22;
        #1;
        chk("bypass_ready", {31'b0, ready}, 32'h1);
        step();
        chk("bypass_valid1", {31'b0, v1}, 32'h1);
        chk("bypass_data1", d1, 32'h22);
        chk("bypass_data0", d0, 32'h11);
        valid = 1'b0; rdy0 = 1'b1; rdy1 = 1'b1;
        step();
        chk("drain_valid0", {31'b0, v0}, 32'h0);
        chk("drain_valid1", {31'b0, v1}, 32'h0);
        chk("drain_cnt0", {24'b0, c0}, 32'd3);
        chk("drain_cnt1", {24'b0, c1}, 32'd3);

        // Fill both ports, then a partial-cycle reset pulse clears them at once.
        idle_inputs();
        valid = 1'b1; sel = 1'b0; data = 32'hA5A5;
        step();
        sel = 1'b1; data = 32'h5A5A;
        step();
        valid = 1'b0;
        chk("prepulse_valid0", {31'b0, v0}, 32'h1);
        chk("prepulse_valid1", {31'b0, v1}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("pulse_valid0", {31'b0, v0}, 32'h0);
        chk("pulse_valid1", {31'b0, v1}, 32'h0);
        chk("pulse_data0", d0, 32'h0);
        chk("pulse_data1", d1, 32'h0);
        chk("pulse_cnt0", {24'b0, c0}, 32'h0);
        chk("pulse_cnt1", {24'b0, c1}, 32'h0);
        chk("pulse_ready", {31'b0, ready}, 32'h0);
        #1;
        rst_n = 1'b1;

        // Stream 1..8 to port 1 with the sink always ready.
        idle_inputs();
        sel = 1'b1; rdy1 = 1'b1; valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            data = k;
            step();
            chk("stream_valid1", {31'b0, v1}, 32'h1);
            chk("stream_data1", d1, k);
        end
        valid = 1'b0;
        step();
        chk("stream_cnt1", {24'b0, c1}, 32'd8);
        chk("stream_valid1_end", {31'b0, v1}, 32'h0);

        // 256 deliveries on port 0 wrap its counter; port 1 count untouched.
        idle_inputs();
        rdy0 = 1'b1; valid = 1'b1;
        for (int k = 0; k < 256; k++) begin
            data = k;
            step();
            if (k == 255) chk("wrap_cnt0_255", {24'b0, c0}, 32'd255);
        end
        valid = 1'b0;
        step();
        chk("wrap_cnt0", {24'b0, c0}, 32'd0);
        chk("wrap_cnt1", {24'b0, c1}, 32'd8);
        chk("wrap_data0", d0, 32'd255);

        // First transfer on the first edge after reset release.
        do_reset();
        valid = 1'b1; sel = 1'b0; data = 32'hDEADBEEF; rdy0 = 1'b1;
        #1;
        chk("rel_ready", {31'b0, ready}, 32'h1);
        step();
        chk("rel_valid0", {31'b0, v0}, 32'h1);
        chk("rel_data0", d0, 32'hDEADBEEF);
        chk("rel_valid1", {31'b0, v1}, 32'h0);
        valid = 1'b0;
        step();
        chk("rel_cnt0", {24'b0, c0}, 32'd1);

        // Randomised traffic against per-port queues.
        do_reset();
        ec0 = 8'd0;
        ec1 = 8'd0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            valid = 1'($urandom_range(0, 1));
            sel   = 1'($urandom_range(0, 1));
            data  = $urandom;
            rdy0  = 1'($urandom_range(0, 3) != 0);
            rdy1  = 1'($urandom_range(0, 2) == 0);
            #1;
            e_rdy = sel ? ((q1.size() == 0) || rdy1) : ((q0.size() == 0) || rdy0);
            chk("rnd_ready", {31'b0, ready}, {31'b0, e_rdy});
            chk("rnd_valid0", {31'b0, v0}, {31'b0, q0.size() != 0});
            chk("rnd_valid1", {31'b0, v1}, {31'b0, q1.size() != 0});
            if (q0.size() != 0) chk("rnd_data0", d0, q0[0]);
            if (q1.size() != 0) chk("rnd_data1", d1, q1[0]);
            acc = valid && e_rdy;
            step();
            if ((q0.size() != 0) && rdy0) begin
                void'(q0.pop_front());
                ec0 = ec0 + 8'd1;
            end
            if ((q1.size() != 0) && rdy1) begin
                void'(q1.pop_front());
                ec1 = ec1 + 8'd1;
            end
            if (acc) begin
                if (sel) q1.push_back(data);
                else     q0.push_back(data);
            end
        end
        chk("rnd_cnt0", {24'b0, c0}, {24'b0, ec0});
        chk("rnd_cnt1", {24'b0, c1}, {24'b0, ec1});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
